// File: rtl/move_lane_packer.sv
// Move lane packer: takes a word of LANES move slots, compacts the valid ones into a
// circular FIFO one per cycle, and serves them on a show-ahead valid/ready read port.
module move_lane_packer #(
  parameter int LANES = 8,
  parameter int MW    = 19,
  parameter int DEPTH = 64,
  parameter int WDT   = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clear_i,
  input  logic                     wr_en_i,
  input  logic [LANES*MW-1:0]      wr_data_i,
  output logic                     wr_ready_o,
  output logic [MW-1:0]            rd_data_o,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o,
  output logic                     overflow_o
);
  // state | meaning
  // IDLE  | lane register empty, ready for the next input word
  // PACK  | draining masked lanes into the FIFO, lowest lane first

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(WDT + 1);

  typedef enum logic {IDLE, PACK} state_t;

  state_t                state_q;
  logic [LANES*MW-1:0]   lane_q;
  logic [LANES-1:0]      mask_q;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [TW-1:0]         stall_q;
  logic                  overflow_q;
  logic [MW-1:0]         mem_q [DEPTH];

  logic [LANES-1:0]      in_mask;
  logic [LANES-1:0]      sel_onehot;
  logic [LANES-1:0]      mask_clr;
  logic [MW-1:0]         lane_sel;
  logic                  found;
  logic                  full;
  logic                  push;
  logic                  pop;

  always_comb begin
    in_mask = '0;
    for (int i = 0; i < LANES; i++) in_mask[i] = ~wr_data_i[i*MW + MW - 1];
  end

  // Scan from the top down so the lowest set lane wins.
  always_comb begin
    sel_onehot = '0;
    lane_sel   = '0;
    found      = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        lane_sel      = lane_q[i*MW +: MW];
        found         = 1'b1;
      end
    end
  end

  assign mask_clr   = mask_q & ~sel_onehot;
  assign full       = (count_q == CW'(DEPTH));
  assign push       = (state_q == PACK) && found && !full;
  assign rd_valid_o = (count_q != '0);
  assign pop        = rd_valid_o && rd_ready_i;

  assign wr_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q == PACK);
  assign overflow_o = overflow_q;
  assign count_o    = count_q;
  assign rd_data_o  = {1'b0, mem_q[rd_ptr_q][MW-2:0]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      mask_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      mask_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (wr_en_i) begin
            lane_q  <= wr_data_i;
            mask_q  <= in_mask;
            stall_q <= '0;
            if (|in_mask) state_q <= PACK;
          end
        end
        PACK: begin
          if (push) begin
            mask_q  <= mask_clr;
            stall_q <= '0;
            if (mask_clr == '0) state_q <= IDLE;
          end else if (stall_q == TW'(WDT - 1)) begin
            // Watchdog expired: discard the remaining lanes and flag it.
            overflow_q <= 1'b1;
            mask_q     <= '0;
            stall_q    <= '0;
            state_q    <= IDLE;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear_i) mem_q[wr_ptr_q] <= lane_sel;
  end

endmodule

// File: tb/tb_move_lane_packer.sv
// Directed bench for move_lane_packer (LANES=8, MW=19, DEPTH=8, WDT=15).
module tb_move_lane_packer;
  localparam int LANES = 8;
  localparam int MW    = 19;
  localparam int DEPTH = 8;
  localparam int WDT   = 15;
  localparam logic [MW-1:0] INV = 19'h40000;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   clear;
  logic                   wr_en;
  logic [LANES*MW-1:0]    wr_data;
  logic                   wr_ready;
  logic [MW-1:0]          rd_data;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;
  logic                   overflow;

  int tests = 0;
  int fails = 0;

  move_lane_packer #(.LANES(LANES), .MW(MW), .DEPTH(DEPTH), .WDT(WDT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .wr_ready_o(wr_ready), .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .count_o(count), .busy_o(busy), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] mv(input int flags, input int from, input int to);
    logic [5:0] f, s, d;
    f = 6'(flags);
    s = 6'(from);
    d = 6'(to);
    return {1'b0, f, s, d};
  endfunction

  function automatic logic [LANES*MW-1:0] mkword(input int tag, input logic [7:0] vmask);
    logic [LANES*MW-1:0] w;
    w = '0;
    for (int i = 0; i < LANES; i++)
      w[i*MW +: MW] = vmask[i] ? mv(tag, i, tag * 8 + i) : INV;
    return w;
  endfunction

  logic [MW-1:0] exp_q[$];
  logic [LANES*MW-1:0] w;
  logic [7:0] pats [6];
  int idx;
  int cyc;
  logic done;
  logic pbusy, pvalid;
  logic [$clog2(DEPTH):0] pcount;

  initial begin
    rst_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (2) tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    tick();

    // Lanes 1,4,7 valid, consumer always ready
    w = {LANES{INV}};
    w[1*MW +: MW] = mv(0, 6'o12, 6'o22);
    w[4*MW +: MW] = mv(0, 6'o33, 6'o44);
    w[7*MW +: MW] = mv(0, 6'o70, 6'o60);
    rd_ready = 1'b1; wr_en = 1'b1; wr_data = w;
    tick();
    wr_en = 1'b0;
    chk("t2_busy_c1", 32'(busy), 1);
    chk("t2_rdv_c1", 32'(rd_valid), 0);
    chk("t2_wrr_c1", 32'(wr_ready), 0);
    tick();
    chk("t2_rdv_c2", 32'(rd_valid), 1);
    chk("t2_lane1", 32'(rd_data), 32'(mv(0, 6'o12, 6'o22)));
    chk("t2_busy_c2", 32'(busy), 1);
    tick();
    chk("t2_lane4", 32'(rd_data), 32'(mv(0, 6'o33, 6'o44)));
    chk("t2_count_c3", 32'(count), 1);
    chk("t2_busy_c3", 32'(busy), 1);
    tick();
    chk("t2_lane7", 32'(rd_data), 32'(mv(0, 6'o70, 6'o60)));
    chk("t2_busy_c4", 32'(busy), 0);
    chk("t2_wrr_c4", 32'(wr_ready), 1);
    tick();
    chk("t2_empty", 32'(rd_valid), 0);
    chk("t2_count_end", 32'(count), 0);

    // All-invalid word is dropped silently
    wr_en = 1'b1; wr_data = {LANES{INV}};
    tick();
    wr_en = 1'b0;
    chk("t3_wrr", 32'(wr_ready), 1);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_count", 32'(count), 0);
    chk("t3_ovf", 32'(overflow), 0);

    // Async reset mid-PACK after 3 of 8 lanes written
    rd_ready = 1'b0; wr_en = 1'b1; wr_data = mkword(1, 8'hFF);
    tick();
    wr_en = 1'b0;
    repeat (3) tick();
    chk("t1_count_pre", 32'(count), 3);
    chk("t1_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t1_count", 32'(count), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_wrr", 32'(wr_ready), 1);
    chk("t1_rdv", 32'(rd_valid), 0);
    #2;
    rst_n = 1'b1;
    tick();

    // Fill FIFO, then stall a second word into the watchdog
    wr_en = 1'b1; wr_data = mkword(2, 8'hFF);
    tick();
    wr_en = 1'b0;
    repeat (8) tick();
    chk("t4_full", 32'(count), 8);
    chk("t4_idle", 32'(busy), 0);
    wr_en = 1'b1; wr_data = mkword(3, 8'hFF);
    tick();
    wr_en = 1'b0;
    repeat (14) tick();
    chk("t4_stall_busy", 32'(busy), 1);
    chk("t4_stall_ovf", 32'(overflow), 0);
    chk("t4_stall_count", 32'(count), 8);
    tick();
    chk("t4_ovf", 32'(overflow), 1);
    chk("t4_drop_busy", 32'(busy), 0);
    chk("t4_drop_wrr", 32'(wr_ready), 1);
    chk("t4_drop_count", 32'(count), 8);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_pop_valid", 32'(rd_valid), 1);
      chk("t4_pop_data", 32'(rd_data), 32'(mv(2, i, 16 + i)));
      tick();
    end
    rd_ready = 1'b0;
    chk("t4_drained", 32'(count), 0);
    chk("t4_ovf_sticky", 32'(overflow), 1);

    // Clear in the same cycle as an accept and a pop
    wr_en = 1'b1; wr_data = mkword(4, 8'h01);
    tick();
    wr_en = 1'b0;
    tick();
    chk("t6_count_pre", 32'(count), 1);
    clear = 1'b1; wr_en = 1'b1; wr_data = mkword(5, 8'hFF); rd_ready = 1'b1;
    tick();
    clear = 1'b0; wr_en = 1'b0; rd_ready = 1'b0;
    chk("t6_count", 32'(count), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_wrr", 32'(wr_ready), 1);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_rdv", 32'(rd_valid), 0);
    repeat (2) tick();
    chk("t6_discarded", 32'(count), 0);

    // Sustained back-to-back words with consumer always ready
    pats[0] = 8'hFF; pats[1] = 8'hA5; pats[2] = 8'hFF;
    pats[3] = 8'h81; pats[4] = 8'hFF; pats[5] = 8'hFF;
    idx = 0; done = 1'b0; rd_ready = 1'b1;
    pbusy = 1'b0; pvalid = 1'b0; pcount = '0;
    for (cyc = 0; cyc < 300 && !done; cyc++) begin
      if (pbusy && pvalid) chk("t5_count_const", 32'(count), 32'(pcount));
      chk("t5_count_max", 32'(count <= DEPTH), 1);
      if (rd_valid) begin
        if (exp_q.size() == 0) chk("t5_unexpected", 32'(rd_data), 0);
        else chk("t5_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
      if (wr_ready && idx < 6) begin
        wr_en = 1'b1;
        wr_data = mkword(8 + idx, pats[idx]);
        for (int i = 0; i < LANES; i++)
          if (pats[idx][i]) exp_q.push_back(mv(8 + idx, i, (8 + idx) * 8 + i));
        idx++;
      end else begin
        wr_en = 1'b0;
      end
      if (idx == 6 && exp_q.size() == 0 && !busy && !wr_en) done = 1'b1;
      pbusy = busy; pvalid = rd_valid; pcount = count;
      if (!done) tick();
    end
    wr_en = 1'b0;
    chk("t5_done", 32'(done), 1);
    tick();
    chk("t5_count_end", 32'(count), 0);
    chk("t5_ovf_end", 32'(overflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
